// File: rtl/rv32_enc_pkg.sv
// rv32_enc_pkg
// Shared definitions for the RV32 instruction encoder slice.
// Contents:
//   - fmt_e      : instruction format selector (R/I/S/B/U/J; codes 6/7 are illegal)
//   - OP_*       : base opcodes for the formats the encoder is usually driven with
//   - *_W        : field widths used in port declarations
//   - ENTRY_W    : width of one buffered entry (error tag + 32-bit instruction)
package rv32_enc_pkg;

  localparam int XLEN     = 32;
  localparam int FMT_W    = 3;
  localparam int OPCODE_W = 7;
  localparam int REG_W    = 5;
  localparam int FN3_W    = 3;
  localparam int FN7_W    = 7;
  localparam int ENTRY_W  = XLEN + 1;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [OPCODE_W-1:0] OP_REG    = 7'h33;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'h13;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'h37;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/rv32_enc_fifo.sv
// rv32_enc_fifo
// Small synchronous FIFO holding encoded entries (error tag + instruction)
// between the encoder and its consumer.
// Parameters:
//   DEPTH  : number of entries, power of two, >= 2
//   WIDTH  : entry width
// Ports:
//   clk, rst_n            : rising-edge clock, synchronous active-low reset
//   push_valid/push_ready : write handshake; push_ready = !full (no bypass)
//   push_data             : entry written on a push
//   pop_valid/pop_ready   : read handshake; pop_valid = !empty
//   pop_data              : head entry, stable until popped
module rv32_enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic push;
  logic pop;

  // Full/empty come from the occupancy counter rather than pointer
  // comparison, so equal pointers are never ambiguous.
  assign push_ready = (occ_q != FULL_OCC);
  assign pop_valid  = (occ_q != '0);
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;
  assign pop_data   = mem_q[rd_ptr_q];

  // Next-state: write at the tail, advance pointers (wrapping naturally
  // because DEPTH is a power of two), and track occupancy. A push and pop
  // in the same cycle leave occupancy unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers. Storage is cleared on reset too, so the head output
  // reads zero straight after reset and nothing buffered leaks through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder
// Packs opcode, register indices, funct3/funct7 and an immediate into a
// 32-bit RV32 instruction word (R/I/S/B/U/J formats) and buffers the result
// in a small output FIFO.
// Optional build macro: RV_ENC_IMM_CHECK_EN
//   defined   -> immediates are range/alignment checked; failures are tagged
//                with out_err=1 (packing still uses the truncated bits)
//   undefined -> immediates are silently truncated
// Parameters:
//   DEPTH : output FIFO entries (power of two, >= 2)
//   CNT_W : width of the popped-instruction counter
// Ports:
//   clk, rst_n          : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready = FIFO not full)
//   fmt                 : 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   op_code, dest_reg, src_reg_1, src_reg_2, fn3, fn7, imm : instruction fields
//   out_valid/out_ready : output handshake
//   instrn, out_err     : head instruction and its error tag
//   err_seen            : sticky flag, any errored entry accepted since reset
//   instr_cnt           : instructions popped, wrapping
module rv32_instr_encoder
  import rv32_enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FMT_W-1:0]    fmt,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic [REG_W-1:0]    dest_reg,
  input  logic [REG_W-1:0]    src_reg_1,
  input  logic [REG_W-1:0]    src_reg_2,
  input  logic [FN3_W-1:0]    fn3,
  input  logic [FN7_W-1:0]    fn7,
  input  logic [XLEN-1:0]     imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     instrn,
  output logic                out_err,
  output logic                err_seen,
  output logic [CNT_W-1:0]    instr_cnt
);

  logic [XLEN-1:0]    enc_instr;
  logic               enc_err;
  logic [ENTRY_W-1:0] head_entry;
  logic               push;
  logic               pop;

  logic               err_seen_q, err_seen_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;

`ifdef RV_ENC_IMM_CHECK_EN
  // An immediate fits N signed bits when every bit from N-1 upward matches
  // the sign, i.e. the upper slice is all zeros or all ones.
  logic fits_12;
  logic fits_13;
  logic fits_21;
  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);
`endif

  // Combinational packing of the fields for the selected format. Fields a
  // format does not use are simply not referenced in that branch. Illegal
  // formats produce a zero word tagged as an error.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (fmt)
      FMT_R: enc_instr = {fn7, src_reg_2, src_reg_1, fn3, dest_reg, op_code};
      FMT_I: enc_instr = {imm[11:0], src_reg_1, fn3, dest_reg, op_code};
      FMT_S: enc_instr = {imm[11:5], src_reg_2, src_reg_1, fn3, imm[4:0], op_code};
      FMT_B: enc_instr = {imm[12], imm[10:5], src_reg_2, src_reg_1, fn3,
                          imm[4:1], imm[11], op_code};
      FMT_U: enc_instr = {imm[31:12], dest_reg, op_code};
      FMT_J: enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], dest_reg, op_code};
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
`ifdef RV_ENC_IMM_CHECK_EN
    case (fmt)
      FMT_I, FMT_S: enc_err = ~fits_12;
      FMT_B:        enc_err = ~fits_13 | imm[0];
      FMT_U:        enc_err = |imm[11:0];
      FMT_J:        enc_err = ~fits_21 | imm[0];
      default:      ;
    endcase
`endif
  end

  rv32_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({enc_err, enc_instr}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_entry)
  );

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign out_err = head_entry[ENTRY_W-1];
  assign instrn  = head_entry[XLEN-1:0];

  // Sticky error flag set on accept of any errored entry, and a counter of
  // popped instructions that wraps at 2^CNT_W.
  always_comb begin
    err_seen_d  = err_seen_q | (push & enc_err);
    instr_cnt_d = instr_cnt_q;
    if (pop) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
  end

  // Status registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_seen_q  <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      err_seen_q  <= err_seen_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign err_seen  = err_seen_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
- Inverse of the RV32 field decoder: packs opcode, register indices, funct3/funct7 and a 32-bit immediate into one 32-bit RISC-V instruction word, for R/I/S/B/U/J formats.
- Valid/ready on both sides, with a small output FIFO for downstream backpressure.
- Sits between a test-program generator / microcode sequencer and instruction memory or the decoder under test.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2)
- CNT_W, 16, width of emitted-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- op_code  in  7  opcode field
- dest_reg  in  5  rd
- src_reg_1  in  5  rs1
- src_reg_2  in  5  rs2
- fn3  in  3  funct3
- fn7  in  7  funct7 (R only)
- imm  in  32  signed immediate, byte offset; U takes imm[31:12]
- out_valid  out  1  instruction available
- out_ready  in  1  consumer accepts
- instrn  out  32  encoded instruction
- out_err  out  1  error tag for instrn
- err_seen  out  1  sticky: any errored instruction accepted since reset
- instr_cnt  out  CNT_W  instructions popped (wraps)

Behaviour:
- Reset: rst_n sampled on clk only, i.e. synchronous active-low. FIFO emptied, pointers 0, out_valid=0, instrn=0, out_err=0, err_seen=0, instr_cnt=0, in_ready=1 on the first cycle after reset.
- Reset mid-operation: all buffered entries are discarded, with no partial output.
- Accept: in_valid & in_ready at edge N. Encoding is combinational from the inputs and is written into the FIFO at N. out_valid is high at N+1 if the FIFO was empty (1-cycle latency).
- Pop: out_valid & out_ready. instrn/out_err show the head entry and are held stable while out_valid & !out_ready.
- in_ready = !full. There is no bypass when full, even if out_ready=1 that cycle. out_valid = !empty.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. A separate occupancy counter (0..DEPTH) gives full/empty.
- Bit packing:
  - R: fn7|rs2|rs1|fn3|rd|op
  - I: imm[11:0]|rs1|fn3|rd|op
  - S: imm[11:5]|rs2|rs1|fn3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|fn3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Unused input fields are ignored for each format.
- Illegal fmt (6/7): entry is stored with instrn=32'h0 and out_err=1.
- err_seen sets on accept of any entry with err=1 and clears only on reset.
- instr_cnt increments on each pop and wraps at 2^CNT_W.

Optional Feature:
- Macro: RV_ENC_IMM_CHECK_EN
- Defined: immediate range/alignment is checked at accept, and a failing entry gets out_err=1. Packing still uses the truncated bits.
  - I/S: -2048..2047
  - B: -4096..4094, imm[0]=0
  - U: imm[11:0]=0
  - J: -1048576..1048574, imm[0]=0
- Not defined: silent truncation; out_err reflects illegal fmt only.

Decomposition:
- Package rv32_enc_pkg:
  - fmt enum constants FMT_R..FMT_J
  - opcode constants (OP_REG 7'h33, OP_IMM 7'h13, OP_STORE 7'h23, OP_BRANCH 7'h63, OP_LUI 7'h37, OP_JAL 7'h6F)
  - field widths
- Sub-module rv32_enc_fifo: DEPTH-entry 33-bit sync FIFO (instrn + err) with valid/ready. The encoder top holds only the packing/check logic and the counters.

Test Plan:
- R add x3,x1,x2 (op 0x33, rd3 rs1 1 rs2 2 fn3 0 fn7 0), out_ready=1 -> instrn=0x002081B3 one cycle after accept, out_err=0, instr_cnt=1.
- I addi x1,x0,-1 (op 0x13, imm=-1) -> 0xFFF00093.
- S sw x2,8(x1) (op 0x23, fn3 2, imm 8) -> 0x0020A423.
- U lui x5 (imm=0x12345000) -> 0x123452B7.
- Backpressure and reset:
  - out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepts; head held.
  - Release out_ready -> both pop in order and in_ready returns.
  - rst_n=0 with 2 entries buffered -> out_valid=0 next cycle, instr_cnt=0.
- Errors:
  - fmt=6 -> instrn=0, out_err=1, err_seen=1.
  - With RV_ENC_IMM_CHECK_EN, I-type imm=2048 -> out_err=1, instrn[31:20]=0x800.
  - Without RV_ENC_IMM_CHECK_EN, same stimulus -> out_err=0.
